preprocess_seq_ctrl: RTL and testbench

//  Sequencer for the preprocess datapath. For each coefficient index in a run it pulses INTT start,

---
 rtl/preprocess_seq_ctrl.sv | 113 +++++++++++
 tb/tb_preprocess_seq_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/preprocess_seq_ctrl.sv
// preprocess_seq_ctrl: per-index INTT/VPU4 sequencing, ping-pong buffer rotation and mux drain tracking
module preprocess_seq_ctrl #(
    parameter int IDX_W    = 12,
    parameter int NUM_BUFS = 3,
    parameter int TMO_W    = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_run_start,
    input  logic [IDX_W-1:0] i_num_coeff,
    output logic             o_busy,
    output logic             o_run_done,
    output logic             o_intt_start,
    input  logic             i_intt_done,
    output logic             o_vpu4_start,
    input  logic             i_vpu4_done,
    output logic             o_pre_switch,
    input  logic             i_mux_done,
    output logic [IDX_W-1:0] o_coeff_index,
    output logic [1:0]       o_buf_level,
    output logic             o_err_timeout,
    output logic             o_err_underflow
);
    typedef enum logic [3:0] {
        S_IDLE, S_INTT_GO, S_INTT_WAIT, S_VPU_GO, S_VPU_WAIT, S_SW_WAIT, S_SWITCH, S_DRAIN, S_DONE
    } state_t;

    localparam logic [1:0]       LVL_MAX  = 2'(NUM_BUFS - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

    state_t           r_state, w_state_next;
    logic [IDX_W-1:0] r_num, r_index;
    logic [1:0]       r_level;
    logic [TMO_W-1:0] r_timer;
    logic             r_err_tmo, r_err_uf;
    logic             w_in_wait, w_timeout, w_sw_ok, w_last, w_tmo_fire, w_inc, w_dec;

    assign w_in_wait = (r_state == S_INTT_WAIT) || (r_state == S_VPU_WAIT) ||
                       (r_state == S_SW_WAIT) || (r_state == S_DRAIN);
    // the cycle that would bring the timer to all-ones is the last one tolerated
    assign w_timeout = w_in_wait && (r_timer == TMO_LAST);
    // a release in the same cycle frees a slot, so a full ring can still switch
    assign w_sw_ok   = (r_level < LVL_MAX) || (i_mux_done && (r_level == LVL_MAX));
    assign w_last    = r_index == r_num - IDX_W'(1);
    assign w_inc     = r_state == S_SWITCH;
    assign w_dec     = i_mux_done && (r_level != 2'd0);

    assign o_busy          = r_state != S_IDLE;
    assign o_run_done      = r_state == S_DONE;
    assign o_intt_start    = r_state == S_INTT_GO;
    assign o_vpu4_start    = r_state == S_VPU_GO;
    assign o_pre_switch    = w_inc;
    assign o_coeff_index   = r_index;
    assign o_buf_level     = r_level;
    assign o_err_timeout   = r_err_tmo;
    assign o_err_underflow = r_err_uf;

    // next state: advance on handshakes; a WAIT state that runs out of time aborts to IDLE
    always_comb begin
        w_state_next = r_state;
        w_tmo_fire   = 1'b0;
        case (r_state)
            S_IDLE:      if (i_run_start) w_state_next = (i_num_coeff == '0) ? S_DRAIN : S_INTT_GO;
            S_INTT_GO:   w_state_next = S_INTT_WAIT;
            S_INTT_WAIT: if (i_intt_done) w_state_next = S_VPU_GO; else w_tmo_fire = w_timeout;
            S_VPU_GO:    w_state_next = S_VPU_WAIT;
            S_VPU_WAIT:  if (i_vpu4_done) w_state_next = S_SW_WAIT; else w_tmo_fire = w_timeout;
            S_SW_WAIT:   if (w_sw_ok) w_state_next = S_SWITCH; else w_tmo_fire = w_timeout;
            S_SWITCH:    w_state_next = w_last ? S_DRAIN : S_INTT_GO;
            S_DRAIN:     if (r_level == 2'd0) w_state_next = S_DONE; else w_tmo_fire = w_timeout;
            S_DONE:      w_state_next = S_IDLE;
            default:     w_state_next = S_IDLE;
        endcase
        if (w_tmo_fire) w_state_next = S_IDLE;
    end

    // state register; the timer restarts whenever a WAIT state is entered
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_timer <= '0;
        end else begin
            r_state <= w_state_next;
            r_timer <= (w_in_wait && (w_state_next == r_state)) ? r_timer + TMO_W'(1) : '0;
        end
    end

    // run length latched on an accepted start; index steps after each non-final switch
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_num   <= '0;
            r_index <= '0;
        end else if ((r_state == S_IDLE) && i_run_start) begin
            r_num   <= i_num_coeff;
            r_index <= '0;
        end else if ((r_state == S_SWITCH) && !w_last) begin
            r_index <= r_index + IDX_W'(1);
        end
    end

    // buffer level with saturating release, plus sticky error flags
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_level   <= 2'd0;
            r_err_tmo <= 1'b0;
            r_err_uf  <= 1'b0;
        end else begin
            r_level   <= r_level + {1'b0, w_inc} - {1'b0, w_dec};
            r_err_tmo <= r_err_tmo | w_tmo_fire;
            r_err_uf  <= r_err_uf | (i_mux_done && (r_level == 2'd0));
        end
    end
endmodule

// File: tb/tb_preprocess_seq_ctrl.sv
// tb_preprocess_seq_ctrl: vector table of runs plus hand sequences, index scoreboard and level model
module tb_preprocess_seq_ctrl;
    localparam int IDX_W = 12;
    localparam int TMO_W = 4;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             i_run_start = 1'b0;
    logic [IDX_W-1:0] i_num_coeff = '0;
    logic             i_intt_done = 1'b0;
    logic             i_vpu4_done = 1'b0;
    logic             i_mux_done = 1'b0;
    logic             o_busy, o_run_done, o_intt_start, o_vpu4_start, o_pre_switch;
    logic [IDX_W-1:0] o_coeff_index;
    logic [1:0]       o_buf_level;
    logic             o_err_timeout, o_err_underflow;

    always #5 clock = ~clock;

    preprocess_seq_ctrl #(.IDX_W(IDX_W), .NUM_BUFS(3), .TMO_W(TMO_W)) dut (
        .clock(clock), .reset_n(reset_n), .i_run_start(i_run_start), .i_num_coeff(i_num_coeff),
        .o_busy(o_busy), .o_run_done(o_run_done), .o_intt_start(o_intt_start),
        .i_intt_done(i_intt_done), .o_vpu4_start(o_vpu4_start), .i_vpu4_done(i_vpu4_done),
        .o_pre_switch(o_pre_switch), .i_mux_done(i_mux_done), .o_coeff_index(o_coeff_index),
        .o_buf_level(o_buf_level), .o_err_timeout(o_err_timeout), .o_err_underflow(o_err_underflow)
    );

    typedef struct {
        int n;
        int intt_dly;
        int vpu_dly;
        int mux_dly;
        int exp_pulses;
        int exp_done;
        int exp_idx;
    } vec_t;

    vec_t vecs[4];
    int   errors = 0;
    int   checks = 0;
    int   n_intt = 0, n_vpu = 0, n_sw = 0, n_done = 0;
    int   intt_dly = 1, vpu_dly = 1, mux_dly = 2;
    bit   mux_auto = 1'b1;
    bit   mux_force = 1'b0;
    int   intt_cnt = 0, vpu_cnt = 0, mux_cnt = 0;
    int   m_lvl = 0;
    bit   m_uf = 1'b0;
    int   q_idx[$];

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int count(int which);
        return (which == 0) ? n_intt : (which == 1) ? n_vpu : n_sw;
    endfunction

    // one cycle: sample at negedge, compare against model, then drive responders for the next edge
    task automatic tick();
        bit s_intt, s_vpu, s_sw;
        int dec;
        @(negedge clock);
        check("buf_level", o_buf_level, m_lvl);
        check("err_underflow", o_err_underflow, m_uf);
        s_intt = o_intt_start;
        s_vpu  = o_vpu4_start;
        s_sw   = o_pre_switch;
        if (o_run_done) n_done++;
        if (s_intt) begin
            n_intt++;
            if (q_idx.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL coeff_index: unexpected intt_start with index %0d", o_coeff_index);
            end else check("coeff_index", o_coeff_index, q_idx.pop_front());
        end
        if (s_vpu) n_vpu++;
        if (s_sw) n_sw++;
        i_intt_done = 1'b0;
        if (intt_cnt > 0) begin intt_cnt--; i_intt_done = (intt_cnt == 0); end
        i_vpu4_done = 1'b0;
        if (vpu_cnt > 0) begin vpu_cnt--; i_vpu4_done = (vpu_cnt == 0); end
        i_mux_done = mux_force;
        mux_force  = 1'b0;
        if (mux_cnt > 0) begin mux_cnt--; if (mux_cnt == 0) i_mux_done = 1'b1; end
        if (s_intt) intt_cnt = intt_dly;
        if (s_vpu) vpu_cnt = vpu_dly;
        if (s_sw && mux_auto) begin
            if (mux_dly == 0) i_mux_done = 1'b1;
            else mux_cnt = mux_dly;
        end
        if (!reset_n) begin
            m_lvl = 0;
            m_uf  = 1'b0;
        end else begin
            dec = (i_mux_done && m_lvl != 0) ? 1 : 0;
            if (i_mux_done && m_lvl == 0) m_uf = 1'b1;
            m_lvl = m_lvl + (s_sw ? 1 : 0) - dec;
        end
    endtask

    task automatic start_run(int n);
        for (int i = 0; i < n; i++) q_idx.push_back(i);
        i_num_coeff = IDX_W'(n);
        i_run_start = 1'b1;
        tick();
        i_run_start = 1'b0;
    endtask

    task automatic wait_for(string name, int which, int k);
        int b = 0;
        while (count(which) < k && b < 200) begin tick(); b++; end
        check(name, count(which), k);
    endtask

    task automatic wait_idle(string name);
        int b = 0;
        while (o_busy && b < 300) begin tick(); b++; end
        check(name, o_busy, 0);
    endtask

    // release buffers one at a time, never in consecutive cycles, until the run ends
    task automatic drain_manual(string name);
        int b = 0;
        while (o_busy && b < 300) begin
            mux_force = (o_buf_level != 2'd0) && !i_mux_done;
            tick();
            b++;
        end
        mux_force = 1'b0;
        check(name, o_busy, 0);
    endtask

    task automatic check_all_zero(string name);
        check({name, "_busy"}, o_busy, 0);
        check({name, "_run_done"}, o_run_done, 0);
        check({name, "_intt_start"}, o_intt_start, 0);
        check({name, "_vpu4_start"}, o_vpu4_start, 0);
        check({name, "_pre_switch"}, o_pre_switch, 0);
        check({name, "_coeff_index"}, o_coeff_index, 0);
        check({name, "_buf_level"}, o_buf_level, 0);
        check({name, "_err_timeout"}, o_err_timeout, 0);
        check({name, "_err_underflow"}, o_err_underflow, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b_i, b_v, b_s, b_d;
        vecs[0] = '{n: 1, intt_dly: 3, vpu_dly: 3, mux_dly: 2, exp_pulses: 1, exp_done: 1, exp_idx: 0};
        vecs[1] = '{n: 3, intt_dly: 1, vpu_dly: 1, mux_dly: 2, exp_pulses: 3, exp_done: 1, exp_idx: 2};
        vecs[2] = '{n: 5, intt_dly: 2, vpu_dly: 1, mux_dly: 1, exp_pulses: 5, exp_done: 1, exp_idx: 4};
        vecs[3] = '{n: 0, intt_dly: 1, vpu_dly: 1, mux_dly: 2, exp_pulses: 0, exp_done: 1, exp_idx: 0};
        repeat (3) tick();
        check_all_zero("reset");
        reset_n = 1'b1;
        tick();
        for (int v = 0; v < 4; v++) begin
            intt_dly = vecs[v].intt_dly;
            vpu_dly  = vecs[v].vpu_dly;
            mux_dly  = vecs[v].mux_dly;
            mux_auto = 1'b1;
            b_i = n_intt; b_v = n_vpu; b_s = n_sw; b_d = n_done;
            start_run(vecs[v].n);
            wait_idle("vec_idle");
            tick();
            check("vec_intt_starts", n_intt - b_i, vecs[v].exp_pulses);
            check("vec_vpu4_starts", n_vpu - b_v, vecs[v].exp_pulses);
            check("vec_pre_switches", n_sw - b_s, vecs[v].exp_pulses);
            check("vec_run_done", n_done - b_d, vecs[v].exp_done);
            check("vec_final_index", o_coeff_index, vecs[v].exp_idx);
            check("vec_err_timeout", o_err_timeout, 0);
            check("vec_scoreboard_left", q_idx.size(), 0);
        end
        // N=0: run_done two cycles after the start cycle, busy gone one cycle later
        b_s = n_sw;
        i_num_coeff = '0;
        i_run_start = 1'b1;
        tick();
        i_run_start = 1'b0;
        check("n0_done_early", o_run_done, 0);
        check("n0_busy", o_busy, 1);
        tick();
        check("n0_run_done", o_run_done, 1);
        tick();
        check("n0_busy_after", o_busy, 0);
        check("n0_no_switch", n_sw - b_s, 0);
        // full ring: hold in SW_WAIT until the consumer releases a buffer
        intt_dly = 1; vpu_dly = 1; mux_auto = 1'b0;
        b_s = n_sw; b_v = n_vpu; b_d = n_done;
        start_run(4);
        wait_for("full_vpu3", 1, b_v + 3);
        repeat (3) tick();
        check("full_switches", n_sw - b_s, 2);
        check("full_level", o_buf_level, 2);
        check("full_index", o_coeff_index, 2);
        check("full_busy", o_busy, 1);
        i_num_coeff = 12'd7;
        i_run_start = 1'b1;
        tick();
        i_run_start = 1'b0;
        check("full_held", n_sw - b_s, 2);
        mux_force = 1'b1;
        tick();
        tick();
        check("full_switch_after_mux", o_pre_switch, 1);
        tick();
        check("full_level_after", o_buf_level, 2);
        drain_manual("full_drain");
        check("full_total_switches", n_sw - b_s, 4);
        check("full_final_index", o_coeff_index, 3);
        check("full_run_done", n_done - b_d, 1);
        check("full_scoreboard_left", q_idx.size(), 0);
        // switch and release in the same cycle at level 1
        b_s = n_sw;
        start_run(2);
        wait_for("same_sw1", 2, b_s + 1);
        mux_auto = 1'b1; mux_dly = 0;
        wait_for("same_sw2", 2, b_s + 2);
        mux_auto = 1'b0;
        tick();
        check("same_cycle_level", o_buf_level, 1);
        drain_manual("same_drain");
        check("same_underflow", o_err_underflow, 0);
        // release with nothing buffered, while idle
        mux_force = 1'b1;
        tick();
        tick();
        check("uf_flag", o_err_underflow, 1);
        check("uf_level", o_buf_level, 0);
        check("uf_idle", o_busy, 0);
        // INTT never answers: abort after 15 cycles in INTT_WAIT
        intt_dly = 0;
        b_i = n_intt; b_d = n_done;
        start_run(1);
        wait_for("tmo_intt", 0, b_i + 1);
        repeat (15) tick();
        check("tmo_not_yet", o_err_timeout, 0);
        check("tmo_busy_before", o_busy, 1);
        tick();
        check("tmo_flag", o_err_timeout, 1);
        check("tmo_busy_after", o_busy, 0);
        tick();
        check("tmo_no_run_done", n_done - b_d, 0);
        // reset mid-VPU_WAIT of the second index
        intt_dly = 1; vpu_dly = 6; mux_auto = 1'b0;
        b_v = n_vpu;
        start_run(2);
        wait_for("rst_vpu2", 1, b_v + 2);
        tick();
        tick();
        check("rst_pre_level", o_buf_level, 1);
        reset_n = 1'b0;
        #1;
        check_all_zero("midrun_reset");
        m_lvl = 0; m_uf = 1'b0;
        intt_cnt = 0; vpu_cnt = 0; mux_cnt = 0;
        q_idx.delete();
        repeat (2) tick();
        reset_n = 1'b1;
        b_i = n_intt;
        repeat (6) tick();
        check("rst_no_restart", n_intt - b_i, 0);
        check("rst_idle", o_busy, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
